// File: rtl/md_init_loader_pkg.sv
// md_init_loader_pkg: shared widths, record layout, state encoding and step-width helper for the init loader.
package md_init_loader_pkg;
  localparam int NUM_CELLS = 32;
  localparam int SUBS_PER_BEAT = 4;
  localparam int SUB_PACKET_WIDTH = 128;
  localparam int AXIS_TDATA_WIDTH = SUBS_PER_BEAT * SUB_PACKET_WIDTH;
  localparam int OFFSET_WIDTH = 23;
  localparam int ELEMENT_WIDTH = 2;
  localparam int PARTICLE_ID_WIDTH = 8;
  localparam int CNT_WIDTH = PARTICLE_ID_WIDTH + 1;
  localparam int NUM_STEPS = NUM_CELLS / SUBS_PER_BEAT;
  localparam int X_LSB = 0;
  localparam int Y_LSB = 32;
  localparam int Z_LSB = 64;
  localparam int ELEM_LSB = 96;
  typedef enum logic [1:0] {IDLE, LOAD, DONE, ERR} init_state_t;
  typedef struct packed {
    logic [OFFSET_WIDTH-1:0] z;
    logic [OFFSET_WIDTH-1:0] y;
    logic [OFFSET_WIDTH-1:0] x;
  } offset_struct_t;
  function automatic int step_width(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  localparam int STEP_WIDTH = step_width(NUM_STEPS);
endpackage

// File: rtl/md_init_loader_group_max.sv
// md_init_group_max: combinational maximum of N packed W-bit counts.
module md_init_group_max #(
  parameter int N = 4,
  parameter int W = 9
) (
  input  logic [N*W-1:0] vals,
  output logic [W-1:0]   max_val
);
  always_comb begin
    max_val = '0;
    for (int i = 0; i < N; i++)
      max_val = vals[i*W +: W] > max_val ? vals[i*W +: W] : max_val;
  end
endmodule

// File: rtl/md_init_loader.sv
// md_init_loader: steers streamed particle records into per-cell caches, one cell group per step.
module md_init_loader import md_init_loader_pkg::*; #(
  parameter int NUM_CELLS = md_init_loader_pkg::NUM_CELLS,
  parameter int SUBS_PER_BEAT = md_init_loader_pkg::SUBS_PER_BEAT,
  parameter int AXIS_TDATA_WIDTH = md_init_loader_pkg::AXIS_TDATA_WIDTH,
  parameter int SUB_PACKET_WIDTH = md_init_loader_pkg::SUB_PACKET_WIDTH,
  parameter int OFFSET_WIDTH = md_init_loader_pkg::OFFSET_WIDTH,
  parameter int ELEMENT_WIDTH = md_init_loader_pkg::ELEMENT_WIDTH,
  parameter int PARTICLE_ID_WIDTH = md_init_loader_pkg::PARTICLE_ID_WIDTH,
  localparam int CNT_WIDTH = PARTICLE_ID_WIDTH + 1,
  localparam int NUM_STEPS = NUM_CELLS / SUBS_PER_BEAT,
  localparam int STEP_WIDTH = step_width(NUM_STEPS)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  i_start,
  input  logic [NUM_CELLS*CNT_WIDTH-1:0]        i_cell_counts,
  input  logic [AXIS_TDATA_WIDTH-1:0]           i_init_tdata,
  input  logic                                  i_init_tvalid,
  input  logic                                  i_init_tlast,
  output logic                                  o_init_tready,
  output logic [PARTICLE_ID_WIDTH-1:0]          o_init_wr_addr,
  output logic [NUM_CELLS*3*OFFSET_WIDTH-1:0]   o_init_data,
  output logic [NUM_CELLS*ELEMENT_WIDTH-1:0]    o_init_element,
  output logic [NUM_CELLS-1:0]                  o_init_wr_en,
  output logic [STEP_WIDTH-1:0]                 o_init_step,
  output logic                                  o_busy,
  output logic                                  o_done,
  output logic                                  o_err
);
  localparam int DW = 3 * OFFSET_WIDTH;
  init_state_t state, state_n;
  logic [CNT_WIDTH-1:0] counts [NUM_CELLS];
  logic [CNT_WIDTH-1:0] counts_n [NUM_CELLS];
  logic [PARTICLE_ID_WIDTH-1:0] addr, addr_n, wr_addr_n;
  logic [STEP_WIDTH-1:0] step, step_n;
  logic [CNT_WIDTH-1:0] grp_max, gmax_n;
  logic [SUBS_PER_BEAT*CNT_WIDTH-1:0] grp_vals;
  logic tready_q, bad, later_nz, grp_last, last_step, accept, final_beat;
  logic [NUM_CELLS-1:0] wr_en_n;
  logic [NUM_CELLS*DW-1:0] data_n;
  logic [NUM_CELLS*ELEMENT_WIDTH-1:0] elem_n;
  logic unused_tdata;
  assign unused_tdata = ^i_init_tdata;
  // grp_max is evaluated for the step being entered so tready can be registered without a bubble
  md_init_group_max #(.N(SUBS_PER_BEAT), .W(CNT_WIDTH)) u_group_max (
    .vals(grp_vals),
    .max_val(gmax_n)
  );
  always_comb begin
    state_n = state;
    counts_n = counts;
    addr_n = addr;
    step_n = step;
    wr_addr_n = '0;
    wr_en_n = '0;
    data_n = '0;
    elem_n = '0;
    bad = 1'b0;
    later_nz = 1'b0;
    grp_vals = '0;
    accept = i_init_tvalid && tready_q;
    grp_last = {1'b0, addr} == grp_max - CNT_WIDTH'(1);
    last_step = step == STEP_WIDTH'(NUM_STEPS - 1);
    for (int c = 0; c < NUM_CELLS; c++) begin
      bad = bad || (i_cell_counts[c*CNT_WIDTH +: CNT_WIDTH] > CNT_WIDTH'(1 << PARTICLE_ID_WIDTH));
      later_nz = later_nz || (c / SUBS_PER_BEAT > int'(step) && counts[c] != '0);
    end
    final_beat = grp_last && !later_nz;
    if (state == LOAD) begin
      if (grp_max == '0) begin
        step_n = step + 1'b1;
        state_n = last_step ? DONE : LOAD;
      end else if (accept) begin
        if (i_init_tlast != final_beat) begin
          state_n = ERR;
        end else begin
          wr_addr_n = addr;
          for (int c = 0; c < NUM_CELLS; c++)
            if (c / SUBS_PER_BEAT == int'(step)) begin
              wr_en_n[c] = {1'b0, addr} < counts[c];
              data_n[c*DW +: DW] = {
                i_init_tdata[(c%SUBS_PER_BEAT)*SUB_PACKET_WIDTH + Z_LSB +: OFFSET_WIDTH],
                i_init_tdata[(c%SUBS_PER_BEAT)*SUB_PACKET_WIDTH + Y_LSB +: OFFSET_WIDTH],
                i_init_tdata[(c%SUBS_PER_BEAT)*SUB_PACKET_WIDTH + X_LSB +: OFFSET_WIDTH]};
              elem_n[c*ELEMENT_WIDTH +: ELEMENT_WIDTH] =
                i_init_tdata[(c%SUBS_PER_BEAT)*SUB_PACKET_WIDTH + ELEM_LSB +: ELEMENT_WIDTH];
            end
          addr_n = grp_last ? '0 : addr + 1'b1;
          step_n = grp_last ? step + 1'b1 : step;
          state_n = grp_last && last_step ? DONE : LOAD;
        end
      end
    end else if (i_start) begin
      for (int c = 0; c < NUM_CELLS; c++)
        counts_n[c] = i_cell_counts[c*CNT_WIDTH +: CNT_WIDTH];
      addr_n = '0;
      step_n = '0;
      state_n = bad ? ERR : LOAD;
    end
    for (int c = 0; c < NUM_CELLS; c++)
      if (c / SUBS_PER_BEAT == int'(step_n))
        grp_vals[(c%SUBS_PER_BEAT)*CNT_WIDTH +: CNT_WIDTH] = counts_n[c];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      counts <= '{default: '0};
      addr <= '0;
      step <= '0;
      grp_max <= '0;
      tready_q <= 1'b0;
      o_init_wr_addr <= '0;
      o_init_wr_en <= '0;
      o_init_data <= '0;
      o_init_element <= '0;
    end else begin
      state <= state_n;
      counts <= counts_n;
      addr <= addr_n;
      step <= step_n;
      grp_max <= gmax_n;
      tready_q <= state_n == LOAD && gmax_n != '0;
      o_init_wr_addr <= wr_addr_n;
      o_init_wr_en <= wr_en_n;
      o_init_data <= data_n;
      o_init_element <= elem_n;
    end
  end
  assign o_init_tready = tready_q;
  assign o_init_step = step;
  assign o_busy = state == LOAD;
  assign o_done = state == DONE;
  assign o_err = state == ERR;
endmodule

// File: tb/tb_md_init_loader.sv
// tb_md_init_loader: directed streams with a scoreboard of expected cache writes for md_init_loader.
module tb_md_init_loader;
  localparam int NC = 32;
  localparam int S = 4;
  localparam int NS = 8;
  localparam int CW = 9;
  localparam int DW = 69;
  typedef struct {
    logic [NC-1:0]    we;
    logic [7:0]       addr;
    logic [NC*DW-1:0] data;
    logic [NC*2-1:0]  el;
    int               cyc;
  } exp_t;
  logic clk = 0, rst_n = 0, i_start = 0, tvalid = 0, tlast = 0;
  logic [NC*CW-1:0] counts_v = '0;
  logic [511:0] tdata = '0;
  logic o_init_tready, o_busy, o_done, o_err;
  logic [7:0] o_init_wr_addr;
  logic [NC*DW-1:0] o_init_data;
  logic [NC*2-1:0] o_init_element;
  logic [NC-1:0] o_init_wr_en;
  logic [2:0] o_init_step;
  exp_t q[$];
  exp_t m_e;
  logic [NC*DW-1:0] dmask;
  logic [NC*2-1:0] emask;
  int checks = 0, errors = 0, cyc = 0, lowcnt = 0;
  int cnt[NC];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  md_init_loader dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_cell_counts(counts_v),
    .i_init_tdata(tdata), .i_init_tvalid(tvalid), .i_init_tlast(tlast),
    .o_init_tready(o_init_tready), .o_init_wr_addr(o_init_wr_addr),
    .o_init_data(o_init_data), .o_init_element(o_init_element),
    .o_init_wr_en(o_init_wr_en), .o_init_step(o_init_step),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask
  function automatic logic [127:0] rec(input int g, input int a, input int j);
    logic [127:0] r = '1;
    logic [22:0] x = 23'(g * 1000 + a * 10 + j);
    r[22:0] = x;
    r[54:32] = x ^ 23'h2AAAA;
    r[86:64] = x + 23'd7;
    r[97:96] = 2'(g + a + j);
    return r;
  endfunction
  // Monitor: every write strobe must match the oldest pending expectation, in the expected cycle.
  always @(negedge clk) begin
    if (rst_n && o_busy && !o_init_tready) lowcnt++;
    if (o_init_wr_en != '0) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: wr_en %0h addr %0d, expected no write", o_init_wr_en, o_init_wr_addr);
      end else begin
        m_e = q.pop_front();
        for (int c = 0; c < NC; c++) begin
          dmask[c*DW +: DW] = {DW{m_e.we[c]}};
          emask[c*2 +: 2] = {2{m_e.we[c]}};
        end
        chk("wr_en", o_init_wr_en, m_e.we);
        chk("wr_addr", o_init_wr_addr, m_e.addr);
        chk("write_cycle", cyc, m_e.cyc);
        chk("element", o_init_element & emask, m_e.el);
        checks++;
        if ((o_init_data & dmask) !== m_e.data) begin
          errors++;
          for (int c = 0; c < NC; c++)
            if ((o_init_data[c*DW +: DW] & dmask[c*DW +: DW]) !== m_e.data[c*DW +: DW])
              $display("FAIL data cell %0d addr %0d: got %h expected %h", c, m_e.addr,
                       o_init_data[c*DW +: DW], m_e.data[c*DW +: DW]);
        end
      end
    end
  end
  task automatic do_start();
    for (int c = 0; c < NC; c++) counts_v[c*CW +: CW] = CW'(cnt[c]);
    i_start = 1;
    lowcnt = 0;
    @(negedge clk);
    i_start = 0;
  endtask
  // err_k: beat index given a wrong tlast; abort_k: beat index at which streaming stops
  task automatic run(input int gap, input int err_k, input int abort_k);
    int gm, k = 0, total = 0, last_g = -1, zg = 0, lat, tries;
    logic [127:0] r;
    exp_t e;
    for (int g = 0; g < NS; g++) begin
      gm = 0;
      for (int j = 0; j < S; j++) gm = cnt[g*S+j] > gm ? cnt[g*S+j] : gm;
      total += gm;
      if (gm > 0) last_g = g; else zg++;
    end
    do_start();
    for (int g = 0; g < NS; g++) begin
      gm = 0;
      for (int j = 0; j < S; j++) gm = cnt[g*S+j] > gm ? cnt[g*S+j] : gm;
      for (int a = 0; a < gm; a++) begin
        if (k == abort_k) begin
          tvalid = 0;
          return;
        end
        for (int j = 0; j < S; j++) tdata[j*128 +: 128] = rec(g, a, j);
        tlast = err_k >= 0 ? k == err_k : k == total - 1;
        tvalid = 1;
        tries = 0;
        while (!o_init_tready && tries < 20) begin
          @(negedge clk);
          tries++;
        end
        if (!o_init_tready) begin
          checks++;
          errors++;
          $display("FAIL tready_timeout: beat %0d not accepted within 20 cycles, expected accept", k);
          tvalid = 0;
          return;
        end
        if (k != err_k) begin
          e.we = '0; e.data = '0; e.el = '0; e.addr = 8'(a); e.cyc = cyc + 1;
          for (int j = 0; j < S; j++) begin
            r = rec(g, a, j);
            if (a < cnt[g*S+j]) begin
              e.we[g*S+j] = 1'b1;
              e.data[(g*S+j)*DW +: DW] = {r[86:64], r[54:32], r[22:0]};
              e.el[(g*S+j)*2 +: 2] = r[97:96];
            end
          end
          q.push_back(e);
        end
        @(negedge clk);
        if (k == err_k) begin
          tvalid = 0;
          tlast = 0;
          chk("err_on_tlast", o_err, 1);
          return;
        end
        k++;
        if (gap != 0 && k < total) begin
          tvalid = 0;
          @(negedge clk);
        end
      end
    end
    tvalid = 0;
    tlast = 0;
    lat = 1;
    while (!o_done && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    chk("done_latency", lat, NS - last_g);
    chk("tready_low_cycles", lowcnt, zg);
    #1;
    chk("queue_drained", q.size(), 0);
    chk("busy_after_done", o_busy, 0);
  endtask
  task automatic check_zero();
    chk("rst_tready", o_init_tready, 0);
    chk("rst_wr_en", o_init_wr_en, 0);
    chk("rst_data", o_init_data != '0, 0);
    chk("rst_element", o_init_element, 0);
    chk("rst_addr", o_init_wr_addr, 0);
    chk("rst_step", o_init_step, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_err", o_err, 0);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check_zero();
    rst_n = 1;
    @(negedge clk);
    for (int c = 0; c < NC; c++) cnt[c] = 3;
    run(0, -1, -1);
    for (int c = 0; c < NC; c++) cnt[c] = 0;
    cnt[0] = 5; cnt[1] = 1; cnt[2] = 0; cnt[3] = 2;
    run(0, -1, -1);
    for (int c = 0; c < NC; c++) cnt[c] = (c / S == 1 || c / S == 2) ? 0 : 1;
    run(0, -1, -1);
    for (int c = 0; c < NC; c++) cnt[c] = 3;
    run(0, 2, -1);
    repeat (3) @(negedge clk);
    chk("err_sticky", o_err, 1);
    chk("err_tready", o_init_tready, 0);
    chk("err_no_writes", q.size(), 0);
    for (int c = 0; c < NC; c++) cnt[c] = 2;
    run(0, -1, -1);
    run(1, -1, -1);
    for (int c = 0; c < NC; c++) cnt[c] = 0;
    run(0, -1, -1);
    for (int c = 0; c < NC; c++) cnt[c] = 1;
    cnt[5] = 257;
    do_start();
    chk("badcount_err", o_err, 1);
    chk("badcount_busy", o_busy, 0);
    for (int i = 0; i < 3; i++) begin
      chk("badcount_tready", o_init_tready, 0);
      @(negedge clk);
    end
    for (int c = 0; c < NC; c++) cnt[c] = 3;
    run(0, -1, 3);
    repeat (2) @(negedge clk);
    chk("midload_busy", o_busy, 1);
    #2 rst_n = 0;
    #1 check_zero();
    chk("midload_writes_drained", q.size(), 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
